// File: rtl/sdram_init_seq.sv
// ============================================================================
// sdram_init_seq: SDRAM power-up initialisation (NOP wait, PRECHARGE ALL,
// N x AUTO REFRESH, LOAD MODE REGISTER) followed by an optional periodic
// refresh-request timer compiled in by defining SDRAM_REFRESH_TIMER_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sdram_init_seq #(
  parameter int          FREQ             = 50000000,
  parameter int          T_POWERUP_US     = 100,
  parameter int          T_RP_CYC         = 3,
  parameter int          T_RFC_CYC        = 9,
  parameter int          T_MRD_CYC        = 2,
  parameter int          N_INIT_REF       = 8,
  parameter logic [12:0] MODE_REG         = 13'h022,
  parameter int          REF_INTERVAL_CYC = 390
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_cke,
  output logic [3:0]  o_cmd,
  output logic [12:0] o_addr,
  output logic [1:0]  o_ba,
  output logic        o_init_done,
  output logic        o_ref_req,
  input  logic        i_ref_ack,
  output logic        o_ref_miss
);

  localparam int P  = FREQ / 1000000 * T_POWERUP_US;
  localparam int CW = ($clog2(P + 1) > 16) ? $clog2(P + 1) : 16;

  localparam logic [CW-1:0] C_PWR_LAST = CW'(P);
  localparam logic [CW-1:0] C_RP_LAST  = CW'(T_RP_CYC - 1);
  localparam logic [CW-1:0] C_RFC_LAST = CW'(T_RFC_CYC - 1);
  localparam logic [CW-1:0] C_MRD_LAST = CW'(T_MRD_CYC - 1);
  localparam logic [3:0]    C_N_REF    = 4'(N_INIT_REF);

  localparam logic [3:0] C_CMD_NOP  = 4'b0111;
  localparam logic [3:0] C_CMD_PRE  = 4'b0010;
  localparam logic [3:0] C_CMD_AREF = 4'b0001;
  localparam logic [3:0] C_CMD_LMR  = 4'b0000;

  typedef enum logic [2:0] {
    S_WAIT_PWR  = 3'd0,
    S_PRECHARGE = 3'd1,
    S_WAIT_RP   = 3'd2,
    S_REFRESH   = 3'd3,
    S_WAIT_RFC  = 3'd4,
    S_LOAD_MODE = 3'd5,
    S_WAIT_MRD  = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     ref_cnt_q, ref_cnt_d;
  logic           cke_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_WAIT_PWR;
      cnt_q     <= '0;
      ref_cnt_q <= '0;
      cke_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_cnt_q <= ref_cnt_d;
      cke_q     <= 1'b1;
    end
  end

  // The reset interval itself is not counted, so the power-up wait compares
  // against P rather than P-1 to give exactly P NOP cycles after release.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_cnt_d = ref_cnt_q;
    o_cmd     = C_CMD_NOP;
    o_addr    = 13'h0000;
    case (state_q)
      S_WAIT_PWR: begin
        if (cnt_q == C_PWR_LAST) begin
          state_d = S_PRECHARGE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PRECHARGE: begin
        o_cmd   = C_CMD_PRE;
        o_addr  = 13'h0400;
        state_d = S_WAIT_RP;
      end
      S_WAIT_RP: begin
        if (cnt_q == C_RP_LAST) begin
          state_d = S_REFRESH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_REFRESH: begin
        o_cmd     = C_CMD_AREF;
        ref_cnt_d = ref_cnt_q + 4'd1;
        state_d   = S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        if (cnt_q == C_RFC_LAST) begin
          state_d = (ref_cnt_q == C_N_REF) ? S_LOAD_MODE : S_REFRESH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOAD_MODE: begin
        o_cmd   = C_CMD_LMR;
        o_addr  = MODE_REG;
        state_d = S_WAIT_MRD;
      end
      S_WAIT_MRD: begin
        if (cnt_q == C_MRD_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_WAIT_PWR;
      end
    endcase
  end

  assign o_cke       = cke_q;
  assign o_ba        = 2'b00;
  assign o_init_done = (state_q == S_DONE);

`ifdef SDRAM_REFRESH_TIMER_EN
  localparam int            TW          = (REF_INTERVAL_CYC > 1) ? $clog2(REF_INTERVAL_CYC) : 1;
  localparam logic [TW-1:0] C_TMR_LAST  = TW'(REF_INTERVAL_CYC - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          ref_req_q, ref_req_d;
  logic          ref_miss_q, ref_miss_d;
  logic          expire;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmr_q      <= '0;
      ref_req_q  <= 1'b0;
      ref_miss_q <= 1'b0;
    end else begin
      tmr_q      <= tmr_d;
      ref_req_q  <= ref_req_d;
      ref_miss_q <= ref_miss_d;
    end
  end

  // An expiry always wins over a same-cycle ack: the new interval is due.
  always_comb begin
    tmr_d      = tmr_q;
    ref_req_d  = ref_req_q;
    ref_miss_d = ref_miss_q;
    expire     = 1'b0;
    if (state_q == S_DONE) begin
      expire = (tmr_q == C_TMR_LAST);
      tmr_d  = expire ? '0 : tmr_q + TW'(1);
    end
    if (expire) begin
      ref_req_d = 1'b1;
      if (ref_req_q && !i_ref_ack) begin
        ref_miss_d = 1'b1;
      end
    end else if (ref_req_q && i_ref_ack) begin
      ref_req_d = 1'b0;
    end
  end

  assign o_ref_req  = ref_req_q;
  assign o_ref_miss = ref_miss_q;
`else
  logic unused_ref_ack;
  assign unused_ref_ack = i_ref_ack;
  assign o_ref_req      = 1'b0;
  assign o_ref_miss     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdram_init_seq.sv
// ============================================================================
// tb_sdram_init_seq: directed bench for sdram_init_seq with T_POWERUP_US=1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sdram_init_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ack = 1'b0;
  logic        cke;
  logic [3:0]  cmd;
  logic [12:0] addr;
  logic [1:0]  ba;
  logic        done;
  logic        req;
  logic        miss;

  int checks   = 0;
  int failures = 0;
  int cyc      = -1;

  sdram_init_seq #(
    .FREQ             (50000000),
    .T_POWERUP_US     (1),
    .T_RP_CYC         (3),
    .T_RFC_CYC        (9),
    .T_MRD_CYC        (2),
    .N_INIT_REF       (8),
    .MODE_REG         (13'h022),
    .REF_INTERVAL_CYC (390)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .o_cke       (cke),
    .o_cmd       (cmd),
    .o_addr      (addr),
    .o_ba        (ba),
    .o_init_done (done),
    .o_ref_req   (req),
    .i_ref_ack   (ack),
    .o_ref_miss  (miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cke"},  32'(cke),  32'd0);
    chk({tag, "_cmd"},  32'(cmd),  32'h7);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_ba"},   32'(ba),   32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_req"},  32'(req),  32'd0);
    chk({tag, "_miss"}, 32'(miss), 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
  endtask

  // Expected init command timeline with a 50-cycle power-up wait.
  function automatic logic [3:0] exp_cmd(input int k);
    if (k == 50)  return 4'b0010;
    if (k == 134) return 4'b0000;
    if (k >= 54 && k <= 124 && ((k - 54) % 10) == 0) return 4'b0001;
    return 4'b0111;
  endfunction

  function automatic logic [12:0] exp_addr(input int k);
    if (k == 50)  return 13'h0400;
    if (k == 134) return 13'h0022;
    return 13'h0000;
  endfunction

  task automatic run_init(input int upto);
    while (cyc < upto) begin
      tick();
      chk("cmd",  32'(cmd),  32'(exp_cmd(cyc)));
      chk("addr", 32'(addr), 32'(exp_addr(cyc)));
      chk("ba",   32'(ba),   32'd0);
      chk("cke",  32'(cke),  32'd1);
      chk("done", 32'(done), (cyc >= 137) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst0");

    release_rst();
    run_init(140);

`ifdef SDRAM_REFRESH_TIMER_EN
    run_to(526);
    chk("req_pre",   32'(req),  32'd0);
    tick();
    chk("req_rise",  32'(req),  32'd1);
    run_to(916);
    chk("miss_pre",  32'(miss), 32'd0);
    tick();
    chk("miss_rise", 32'(miss), 32'd1);
    chk("req_held",  32'(req),  32'd1);
`else
    for (int i = 0; i < 2000; i++) begin
      ack = 1'($urandom_range(0, 1));
      tick();
      chk("req_off",  32'(req),  32'd0);
      chk("miss_off", 32'(miss), 32'd0);
    end
    ack = 1'b0;
`endif

    // Asynchronous reset in the middle of the init refresh loop.
    rst = 1'b1;
    release_rst();
    run_init(90);
    rst = 1'b1;
    #1;
    chk_reset("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst_hold");
    release_rst();
    run_init(140);

`ifdef SDRAM_REFRESH_TIMER_EN
    run_to(528);
    chk("req_up",     32'(req), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("req_acked",  32'(req), 32'd0);
    run_to(600);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("ack_ignore", 32'(req), 32'd0);
    run_to(916);
    chk("req_pre2",   32'(req), 32'd0);
    tick();
    chk("req_rise2",  32'(req), 32'd1);
    chk("miss_clr",   32'(miss), 32'd0);
    run_to(1306);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("req_coinc",  32'(req),  32'd1);
    chk("miss_coinc", 32'(miss), 32'd0);
    tick();
    chk("req_after",  32'(req),  32'd1);
    run_to(1696);
    chk("miss_pre3",  32'(miss), 32'd0);
    tick();
    chk("miss_rise3", 32'(miss), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
